// File: rtl/fll_cfg_pkg.sv
// Shared types and constants for the FLL configuration sequencer.
// Latency: n/a (package only).
// Backpressure: n/a.
package fll_cfg_pkg;

    typedef enum logic [2:0] {
        BOOT_WR1,
        BOOT_WR2,
        LOCK_WAIT,
        RUN,
        SW_XFER
    } state_t;

    localparam logic [1:0]  FLL_ADDR_CFG1  = 2'd1;
    localparam logic [1:0]  FLL_ADDR_CFG2  = 2'd2;

    // Read data returned to software when the FLL never acknowledges.
    localparam logic [31:0] XFER_TMO_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/fll_cfg_xfer.sv
// Single-transfer req/ack engine for the FLL config port, with ack timeout.
// Latency: request issued the cycle after start_i; done_o/tmo_o are combinational from the live request.
// Backpressure: start_i is ignored while a request is outstanding; request fields stay frozen until ack or timeout.
//
// Ports: start_i/wrn_i/add_i/data_i launch a transfer; done_o pulses on ack, tmo_o on
// ACK_TIMEOUT request cycles without ack; fll_* drive the FLL config port.
module fll_cfg_xfer #(
    parameter int ACK_TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        start_i,
    input  logic        wrn_i,
    input  logic [1:0]  add_i,
    input  logic [31:0] data_i,
    output logic        done_o,
    output logic        tmo_o,
    output logic        fll_req_o,
    output logic        fll_wrn_o,
    output logic [1:0]  fll_add_o,
    output logic [31:0] fll_data_o,
    input  logic        fll_ack_i
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    logic          req_q,  req_d;
    logic          wrn_q,  wrn_d;
    logic [1:0]    add_q,  add_d;
    logic [31:0]   data_q, data_d;
    logic [CW-1:0] cnt_q,  cnt_d;

    always_comb begin
        req_d  = req_q;
        wrn_d  = wrn_q;
        add_d  = add_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        done_o = req_q & fll_ack_i;
        // cnt_q counts request cycles already spent without ack; this is the last allowed one.
        tmo_o  = req_q & ~fll_ack_i & (cnt_q == CW'(ACK_TIMEOUT - 1));

        if (!req_q) begin
            if (start_i) begin
                req_d  = 1'b1;
                wrn_d  = wrn_i;
                add_d  = add_i;
                data_d = data_i;
                cnt_d  = '0;
            end
        end else if (done_o || tmo_o) begin
            req_d = 1'b0;
        end else if (cnt_q != CW'(ACK_TIMEOUT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            req_q  <= 1'b0;
            wrn_q  <= 1'b0;
            add_q  <= '0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            req_q  <= req_d;
            wrn_q  <= wrn_d;
            add_q  <= add_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign fll_req_o  = req_q;
    assign fll_wrn_o  = wrn_q;
    assign fll_add_o  = add_q;
    assign fll_data_o = data_q;

endmodule

// File: rtl/fll_cfg_ctrl.sv
// FLL config sequencer: boot writes, lock wait, clock switch, then software access to the FLL config port.
// Latency: 2 cycles per transfer with combinational ack; lock decisions lag fll_lock_i by 2 synchroniser cycles.
// Backpressure: sw_req_i is held off until RUN and is not accepted in the sw_ack_o cycle.
//
// Ports: sw_* is the software requester (req held until one-cycle ack); fll_* is the FLL
// config port; clk_sel_o selects the FLL clock; busy_o/lock_err_o/ack_err_o report status.
module fll_cfg_ctrl
    import fll_cfg_pkg::*;
#(
    parameter logic [31:0] BOOT_CFG1    = 32'h0000_0000,
    parameter logic [31:0] BOOT_CFG2    = 32'h0000_0000,
    parameter int          LOCK_STABLE  = 16,
    parameter int          LOCK_TIMEOUT = 4096,
    parameter int          ACK_TIMEOUT  = 64
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        boot_bypass_i,
    input  logic        sw_req_i,
    input  logic        sw_wrn_i,
    input  logic [1:0]  sw_add_i,
    input  logic [31:0] sw_data_i,
    output logic        sw_ack_o,
    output logic [31:0] sw_rdata_o,
    output logic        fll_req_o,
    output logic        fll_wrn_o,
    output logic [1:0]  fll_add_o,
    output logic [31:0] fll_data_o,
    input  logic        fll_ack_i,
    input  logic [31:0] fll_r_data_i,
    input  logic        fll_lock_i,
    output logic        clk_sel_o,
    output logic        busy_o,
    output logic        lock_err_o,
    output logic        ack_err_o
);

    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    state_t        state_q, state_d;
    logic          first_q;
    logic          lock_s1_q, lock_s_q, lock_prev_q;
    logic          clk_sel_q, clk_sel_d;
    logic          lock_err_q, lock_err_d;
    logic          ack_err_q, ack_err_d;
    logic          sw_ack_q, sw_ack_d;
    logic [31:0]   sw_rdata_q, sw_rdata_d;
    logic [SW-1:0] stable_q, stable_d;
    logic [TW-1:0] lto_q, lto_d;

    logic          xfer_start, xfer_wrn, xfer_done, xfer_tmo;
    logic [1:0]    xfer_add;
    logic [31:0]   xfer_data;

    fll_cfg_xfer #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_xfer (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .start_i    (xfer_start),
        .wrn_i      (xfer_wrn),
        .add_i      (xfer_add),
        .data_i     (xfer_data),
        .done_o     (xfer_done),
        .tmo_o      (xfer_tmo),
        .fll_req_o  (fll_req_o),
        .fll_wrn_o  (fll_wrn_o),
        .fll_add_o  (fll_add_o),
        .fll_data_o (fll_data_o),
        .fll_ack_i  (fll_ack_i)
    );

    always_comb begin
        state_d    = state_q;
        clk_sel_d  = clk_sel_q;
        lock_err_d = lock_err_q;
        ack_err_d  = ack_err_q | xfer_tmo;
        sw_ack_d   = 1'b0;
        sw_rdata_d = sw_rdata_q;
        stable_d   = stable_q;
        lto_d      = lto_q;
        xfer_start = 1'b0;
        xfer_wrn   = 1'b0;
        xfer_add   = FLL_ADDR_CFG1;
        xfer_data  = BOOT_CFG1;

        case (state_q)
            BOOT_WR1: begin
                if (first_q && boot_bypass_i) begin
                    state_d = RUN;
                end else begin
                    // Held high for the whole state; the engine ignores it while busy.
                    xfer_start = 1'b1;
                    if (xfer_done || xfer_tmo) state_d = BOOT_WR2;
                end
            end
            BOOT_WR2: begin
                xfer_start = 1'b1;
                xfer_add   = FLL_ADDR_CFG2;
                xfer_data  = BOOT_CFG2;
                if (xfer_done || xfer_tmo) state_d = LOCK_WAIT;
            end
            LOCK_WAIT: begin
                // Stable lock is tested first so it wins a same-cycle tie with the timeout.
                if (stable_q == SW'(LOCK_STABLE)) begin
                    clk_sel_d = 1'b1;
                    state_d   = RUN;
                end else if (lto_q == TW'(LOCK_TIMEOUT)) begin
                    lock_err_d = 1'b1;
                    state_d    = RUN;
                end else begin
                    stable_d = lock_s_q ? stable_q + 1'b1 : '0;
                    lto_d    = lto_q + 1'b1;
                end
            end
            RUN: begin
                // Launching straight from RUN keeps a held requester at one transfer per 3 cycles.
                if (sw_req_i && !sw_ack_q) begin
                    xfer_start = 1'b1;
                    xfer_wrn   = sw_wrn_i;
                    xfer_add   = sw_add_i;
                    xfer_data  = sw_data_i;
                    state_d    = SW_XFER;
                end
            end
            SW_XFER: begin
                if (xfer_done) begin
                    sw_ack_d   = 1'b1;
                    sw_rdata_d = fll_wrn_o ? fll_r_data_i : 32'h0;
                    state_d    = RUN;
                end else if (xfer_tmo) begin
                    sw_ack_d   = 1'b1;
                    sw_rdata_d = XFER_TMO_RDATA;
                    state_d    = RUN;
                end
            end
            default: state_d = BOOT_WR1;
        endcase

        // Lock loss after the switch falls back to the reference clock for good.
        if (clk_sel_q && lock_prev_q && !lock_s_q) begin
            clk_sel_d  = 1'b0;
            lock_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= BOOT_WR1;
            first_q     <= 1'b1;
            lock_s1_q   <= 1'b0;
            lock_s_q    <= 1'b0;
            lock_prev_q <= 1'b0;
            clk_sel_q   <= 1'b0;
            lock_err_q  <= 1'b0;
            ack_err_q   <= 1'b0;
            sw_ack_q    <= 1'b0;
            sw_rdata_q  <= '0;
            stable_q    <= '0;
            lto_q       <= '0;
        end else begin
            state_q     <= state_d;
            first_q     <= 1'b0;
            lock_s1_q   <= fll_lock_i;
            lock_s_q    <= lock_s1_q;
            lock_prev_q <= lock_s_q;
            clk_sel_q   <= clk_sel_d;
            lock_err_q  <= lock_err_d;
            ack_err_q   <= ack_err_d;
            sw_ack_q    <= sw_ack_d;
            sw_rdata_q  <= sw_rdata_d;
            stable_q    <= stable_d;
            lto_q       <= lto_d;
        end
    end

    assign sw_ack_o   = sw_ack_q;
    assign sw_rdata_o = sw_rdata_q;
    assign clk_sel_o  = clk_sel_q;
    assign busy_o     = (state_q != RUN);
    assign lock_err_o = lock_err_q;
    assign ack_err_o  = ack_err_q;

endmodule

// File: tb/tb_fll_cfg_ctrl.sv
// Directed self-checking bench for fll_cfg_ctrl with a combinational ack stub.
// Latency: n/a.
// Backpressure: n/a.
module tb_fll_cfg_ctrl;

    localparam logic [31:0] CFG1 = 32'hA5A5_0001;
    localparam logic [31:0] CFG2 = 32'h5A5A_0002;

    logic        clk = 1'b0;
    logic        rstn;
    logic        boot_bypass;
    logic        sw_req, sw_wrn;
    logic [1:0]  sw_add;
    logic [31:0] sw_data;
    logic        sw_ack_o;
    logic [31:0] sw_rdata_o;
    logic        fll_req_o, fll_wrn_o;
    logic [1:0]  fll_add_o;
    logic [31:0] fll_data_o;
    logic        fll_ack;
    logic [31:0] fll_r_data;
    logic        fll_lock;
    logic        clk_sel_o, busy_o, lock_err_o, ack_err_o;
    logic        ack_en;

    always #5 clk = ~clk;
    assign fll_ack = ack_en & fll_req_o;

    fll_cfg_ctrl #(
        .BOOT_CFG1 (CFG1),
        .BOOT_CFG2 (CFG2),
        .LOCK_STABLE (16),
        .LOCK_TIMEOUT (4096),
        .ACK_TIMEOUT (64)
    ) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .boot_bypass_i (boot_bypass),
        .sw_req_i      (sw_req),
        .sw_wrn_i      (sw_wrn),
        .sw_add_i      (sw_add),
        .sw_data_i     (sw_data),
        .sw_ack_o      (sw_ack_o),
        .sw_rdata_o    (sw_rdata_o),
        .fll_req_o     (fll_req_o),
        .fll_wrn_o     (fll_wrn_o),
        .fll_add_o     (fll_add_o),
        .fll_data_o    (fll_data_o),
        .fll_ack_i     (fll_ack),
        .fll_r_data_i  (fll_r_data),
        .fll_lock_i    (fll_lock),
        .clk_sel_o     (clk_sel_o),
        .busy_o        (busy_o),
        .lock_err_o    (lock_err_o),
        .ack_err_o     (ack_err_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Reset asserted and released on falling edges; the next falling-edge sample is k=1.
    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // One software transfer; nack is the sample index of sw_ack_o (0 if never seen).
    task automatic sw_xfer(input logic wrn, input logic [1:0] add, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int max_cyc,
                           output int nack, output logic [31:0] rd,
                           output logic seen_wrn, output logic [1:0] seen_add,
                           output logic [31:0] seen_data);
        sw_req = 1'b1; sw_wrn = wrn; sw_add = add; sw_data = wdata; fll_r_data = rdata;
        nack = 0; rd = '0; seen_wrn = 1'b0; seen_add = '0; seen_data = '0;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (fll_req_o) begin
                seen_wrn = fll_wrn_o; seen_add = fll_add_o; seen_data = fll_data_o;
            end
            if (sw_ack_o) begin
                nack = i; rd = sw_rdata_o;
                break;
            end
        end
        sw_req = 1'b0;
    endtask

    int          w_k[4];
    logic [1:0]  w_add[4];
    logic [31:0] w_data[4];
    logic        w_wrn[4];
    int          nw, sw_k, loss_n, nack, nreq, early_ack;
    int          acks[8];
    logic        busy_at, lerr_at;
    logic [31:0] rd, s_data;
    logic [1:0]  s_add;
    logic        s_wrn;

    initial begin
        rstn = 1'b0; boot_bypass = 1'b0; sw_req = 1'b0; sw_wrn = 1'b0;
        sw_add = '0; sw_data = '0; fll_r_data = '0; fll_lock = 1'b1; ack_en = 1'b1;

        // ---- reset values ----
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_o, 1);
        chk("rst_clk_sel", clk_sel_o, 0);
        chk("rst_fll_req", fll_req_o, 0);
        chk("rst_sw_ack", sw_ack_o, 0);
        chk("rst_errs", {lock_err_o, ack_err_o}, 0);
        chk("rst_rdata", sw_rdata_o, 0);

        // ---- normal boot: two writes, 2 cycles each, then 16 stable lock cycles ----
        rstn = 1'b1;
        nw = 0; sw_k = 0; busy_at = 1'b1; lerr_at = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (fll_req_o && fll_ack && nw < 4) begin
                w_k[nw] = k; w_add[nw] = fll_add_o; w_data[nw] = fll_data_o; w_wrn[nw] = fll_wrn_o;
                nw++;
            end
            if (clk_sel_o && sw_k == 0) begin
                sw_k = k; busy_at = busy_o; lerr_at = lock_err_o;
            end
        end
        chk("boot_nwrites", nw, 2);
        chk("boot_wr1_cycle", w_k[0], 1);
        chk("boot_wr1_add", w_add[0], 1);
        chk("boot_wr1_data", w_data[0], CFG1);
        chk("boot_wr1_wrn", w_wrn[0], 0);
        chk("boot_wr2_cycle", w_k[1], 3);
        chk("boot_wr2_add", w_add[1], 2);
        chk("boot_wr2_data", w_data[1], CFG2);
        chk("boot_switch_21to23", (sw_k >= 21 && sw_k <= 23), 1);
        chk("boot_busy_at_switch", busy_at, 0);
        chk("boot_lock_err", lerr_at, 0);

        // ---- software read, then write ----
        sw_xfer(1'b1, 2'd0, 32'h0, 32'h1234_5678, 10, nack, rd, s_wrn, s_add, s_data);
        chk("swrd_ack_cycle", nack, 2);
        chk("swrd_rdata", rd, 32'h1234_5678);
        chk("swrd_fll_wrn", s_wrn, 1);
        @(negedge clk);
        chk("swrd_ack_one_cycle", sw_ack_o, 0);
        sw_xfer(1'b0, 2'd3, 32'hCAFE_0003, 32'hFFFF_FFFF, 10, nack, rd, s_wrn, s_add, s_data);
        chk("swwr_ack_cycle", nack, 2);
        chk("swwr_rdata_zero", rd, 0);
        chk("swwr_fll_add", s_add, 3);
        chk("swwr_fll_data", s_data, 32'hCAFE_0003);
        @(negedge clk);

        // ---- held request: one transfer every 3 cycles ----
        sw_req = 1'b1; sw_wrn = 1'b1; sw_add = 2'd0; fll_r_data = 32'h0000_00A1;
        nw = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (sw_ack_o && nw < 8) begin acks[nw] = k; nw++; end
        end
        sw_req = 1'b0;
        chk("b2b_nacks", nw, 4);
        chk("b2b_first", acks[0], 2);
        chk("b2b_period", acks[1] - acks[0], 3);

        // ---- reset during an unacknowledged transfer ----
        @(negedge clk);
        ack_en = 1'b0;
        sw_req = 1'b1; sw_wrn = 1'b0; sw_add = 2'd1; sw_data = 32'h0000_0077;
        repeat (2) @(negedge clk);
        chk("midx_req_pending", fll_req_o, 1);
        chk("midx_clk_sel_before", clk_sel_o, 1);
        #2 rstn = 1'b0;
        #1;
        chk("midx_req_async", fll_req_o, 0);
        chk("midx_clk_sel_async", clk_sel_o, 0);
        chk("midx_busy", busy_o, 1);
        sw_req = 1'b0; ack_en = 1'b1;

        // ---- release with bypass: straight to RUN, no FLL traffic ----
        @(negedge clk);
        boot_bypass = 1'b1;
        rstn = 1'b1;
        @(negedge clk);
        chk("byp_busy", busy_o, 0);
        chk("byp_clk_sel", clk_sel_o, 0);
        nreq = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (fll_req_o) nreq++;
        end
        chk("byp_no_req", nreq, 0);
        boot_bypass = 1'b0;

        // ---- lock glitch at stable count 10, sw request held off during boot ----
        fll_lock = 1'b1;
        sw_req = 1'b1; sw_wrn = 1'b0; sw_add = 2'd3; sw_data = 32'h0000_0BAD;
        do_reset();
        sw_k = 0; early_ack = 0; nreq = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (sw_ack_o) early_ack++;
            if (fll_req_o && fll_add_o == 2'd3) nreq++;
            if (clk_sel_o && sw_k == 0) begin
                sw_k = k;
                sw_req = 1'b0;
            end
            if (k == 12) fll_lock = 1'b0;
            if (k == 13) fll_lock = 1'b1;
        end
        chk("glitch_switch_after_return", sw_k - 13, 19);
        chk("holdoff_no_ack", early_ack, 0);
        chk("holdoff_no_sw_req", nreq, 0);

        // ---- lock lost after the switch ----
        fll_lock = 1'b0;
        loss_n = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (!clk_sel_o && loss_n == 0) loss_n = k;
        end
        chk("loss_within_3", (loss_n >= 1 && loss_n <= 3), 1);
        chk("loss_lock_err", lock_err_o, 1);
        fll_lock = 1'b1;
        repeat (30) @(negedge clk);
        chk("loss_no_reswitch", clk_sel_o, 0);
        chk("loss_err_sticky", lock_err_o, 1);

        // ---- lock never arrives: timeout after 4096 LOCK_WAIT cycles ----
        fll_lock = 1'b0;
        do_reset();
        for (int k = 1; k <= 4101; k++) begin
            @(negedge clk);
            if (k == 4100) begin
                chk("lto_4100_err", lock_err_o, 0);
                chk("lto_4100_busy", busy_o, 1);
            end
        end
        chk("lto_err", lock_err_o, 1);
        chk("lto_busy", busy_o, 0);
        chk("lto_clk_sel", clk_sel_o, 0);
        chk("lto_ack_err", ack_err_o, 0);
        sw_xfer(1'b1, 2'd0, 32'h0, 32'h1234_5678, 10, nack, rd, s_wrn, s_add, s_data);
        chk("lto_swrd_ack", nack, 2);
        chk("lto_swrd_rdata", rd, 32'h1234_5678);
        @(negedge clk);
        chk("lto_swrd_one_cycle", sw_ack_o, 0);

        // ---- ack never arrives: each boot write times out after 64 cycles ----
        fll_lock = 1'b1;
        ack_en = 1'b0;
        do_reset();
        sw_k = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 64) begin
                chk("ato_64_req", fll_req_o, 1);
                chk("ato_64_err", ack_err_o, 0);
            end
            if (k == 65) begin
                chk("ato_65_req", fll_req_o, 0);
                chk("ato_65_err", ack_err_o, 1);
                chk("ato_65_busy", busy_o, 1);
            end
            if (clk_sel_o && sw_k == 0) sw_k = k;
        end
        chk("ato_switch_cycle", sw_k, 147);
        sw_xfer(1'b1, 2'd0, 32'h0, 32'h1234_5678, 100, nack, rd, s_wrn, s_add, s_data);
        chk("ato_swrd_ack", nack, 65);
        chk("ato_swrd_rdata", rd, 32'hDEAD_BEEF);
        chk("ato_swrd_err", ack_err_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
